// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the register file write port.
// Reports pending writes against the two read-port addresses for operand stalls.
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     rf_ld,
    output logic [ADDR_W-1:0]        rf_sel,
    output logic [DATA_W-1:0]        rf_data,
    input  logic                     rf_stall,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic                     rd_hit1,
    output logic                     rd_hit2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count_q;

    logic push;
    logic pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign wb_ready = !full;

    // A full queue refuses pushes even while popping, keeping wb_ready registered-only.
    assign push  = wb_valid && wb_ready;
    assign pop   = !empty && !rf_stall;
    assign rf_ld = pop;

    always_comb begin
        rf_sel  = '0;
        rf_data = '0;
        if (!empty) begin
            rf_sel  = addr_q[head];
            rf_data = data_q[head];
        end
    end

    always_comb begin
        rd_hit1 = 1'b0;
        rd_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == rd_addr1)) rd_hit1 = 1'b1;
            if (valid_q[i] && (addr_q[i] == rd_addr2)) rd_hit2 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (push) begin
                addr_q[tail]  <= wb_addr;
                data_q[tail]  <= wb_data;
                valid_q[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue model checked every cycle plus directed literals.
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [3:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        rf_ld;
    logic [3:0]  rf_sel;
    logic [31:0] rf_data;
    logic        rf_stall = 1'b0;
    logic [3:0]  rd_addr1 = '0;
    logic [3:0]  rd_addr2 = '0;
    logic        rd_hit1;
    logic        rd_hit2;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int vectors = 0;
    int miscompares = 0;

    wb_write_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_ld(rf_ld), .rf_sel(rf_sel), .rf_data(rf_data),
        .rf_stall(rf_stall),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_hit1(rd_hit1), .rd_hit2(rd_hit2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT, and the one the model expects.
    logic [31:0] rf_regs  [16];
    logic [31:0] exp_regs [16];
    int          rf_writes = 0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            rf_regs[i]  = '0;
            exp_regs[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (rf_ld) begin
            rf_regs[rf_sel] = rf_data;
            rf_writes++;
        end
    end

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   exp_push = 0;
    bit   exp_pop  = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            int   n;
            bit   e_empty;
            bit   e_ld;
            bit   h1;
            bit   h2;
            n       = q.size();
            e_empty = (n == 0);
            e_ld    = !e_empty && !rf_stall;
            h1 = 0;
            h2 = 0;
            foreach (q[i]) begin
                if (q[i].a == rd_addr1) h1 = 1;
                if (q[i].a == rd_addr2) h2 = 1;
            end
            chk("count", 32'(count), 32'(n));
            chk("empty", 32'(empty), 32'(e_empty));
            chk("full", 32'(full), 32'(n == 4));
            chk("wb_ready", 32'(wb_ready), 32'(n != 4));
            chk("rf_ld", 32'(rf_ld), 32'(e_ld));
            chk("rf_sel", 32'(rf_sel), e_empty ? 32'd0 : 32'(q[0].a));
            chk("rf_data", rf_data, e_empty ? 32'd0 : q[0].d);
            chk("rd_hit1", 32'(rd_hit1), 32'(h1));
            chk("rd_hit2", 32'(rd_hit2), 32'(h2));
            exp_pop  = e_ld;
            exp_push = wb_valid && (n < 4);
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (exp_pop) begin
                exp_regs[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (exp_push) q.push_back('{a: wb_addr, d: wb_data});
            exp_pop  = 0;
            exp_push = 0;
        end
    end

    always @(negedge rst_n) begin
        q.delete();
        exp_pop  = 0;
        exp_push = 0;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string n, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) chk(n, rf_regs[i], exp_regs[i]);
    endtask

    initial begin
        int wr0;
        int maxc;
        #2 rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;

        // Reset values
        chk("rst count", 32'(count), 32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full", 32'(full), 32'd0);
        chk("rst wb_ready", 32'(wb_ready), 32'd1);
        chk("rst rf_ld", 32'(rf_ld), 32'd0);
        chk("rst rf_sel", 32'(rf_sel), 32'd0);
        chk("rst rf_data", rf_data, 32'd0);
        chk("rst rd_hit1", 32'(rd_hit1), 32'd0);
        chk("rst rd_hit2", 32'(rd_hit2), 32'd0);

        // Single push, one-cycle latency to the register file
        wb_valid = 1'b1;
        wb_addr  = 4'd3;
        wb_data  = 32'hFFFF_FF00;
        cyc();
        wb_valid = 1'b0;
        chk("lat rf_ld", 32'(rf_ld), 32'd1);
        chk("lat rf_sel", 32'(rf_sel), 32'd3);
        chk("lat rf_data", rf_data, 32'hFFFF_FF00);
        cyc();
        chk("lat reg3", rf_regs[3], 32'hFFFF_FF00);
        chk("lat empty", 32'(empty), 32'd1);

        // Fill under stall, then drain
        rf_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1;
            wb_addr  = 4'(i);
            wb_data  = 32'hA0 + 32'(i);
            cyc();
        end
        chk("fill full", 32'(full), 32'd1);
        chk("fill wb_ready", 32'(wb_ready), 32'd0);
        chk("fill count", 32'(count), 32'd4);
        chk("fill rf_ld", 32'(rf_ld), 32'd0);
        chk("fill sel", 32'(rf_sel), 32'd0);
        wb_addr = 4'd9;
        wb_data = 32'hDEAD_BEEF;
        cyc();
        chk("fill 5th", 32'(count), 32'd4);
        wb_valid = 1'b0;
        rf_stall = 1'b0;
        wr0 = rf_writes;
        for (int i = 0; i < 4; i++) cyc();
        chk("drain writes", 32'(rf_writes - wr0), 32'd4);
        chk("drain empty", 32'(empty), 32'd1);
        for (int i = 0; i < 4; i++) chk("drain reg", rf_regs[i], 32'hA0 + 32'(i));
        chk("drain reg9", rf_regs[9], 32'd0);

        // Streaming with wrap-around
        maxc = 0;
        for (int i = 0; i < 10; i++) begin
            wb_valid = 1'b1;
            wb_addr  = 4'(i);
            wb_data  = 32'hFFFF_FF00 + 32'(i);
            cyc();
            if (int'(count) > maxc) maxc = int'(count);
        end
        wb_valid = 1'b0;
        cyc();
        chk("stream maxcount", 32'(maxc), 32'd1);
        for (int i = 0; i < 10; i++) chk("stream reg", rf_regs[i], 32'hFFFF_FF00 + 32'(i));
        chk_regs("stream model", 0, 15);

        // Same-address ordering and hazard flag
        rd_addr1 = 4'd5;
        rd_addr2 = 4'd6;
        rf_stall = 1'b1;
        wb_valid = 1'b1;
        wb_addr  = 4'd5;
        wb_data  = 32'h1;
        chk("hit pre-push", 32'(rd_hit1), 32'd0);
        cyc();
        wb_data = 32'h2;
        cyc();
        wb_valid = 1'b0;
        chk("hit1 queued", 32'(rd_hit1), 32'd1);
        chk("hit2 clear", 32'(rd_hit2), 32'd0);
        rf_stall = 1'b0;
        #1 chk("hit1 popping", 32'(rd_hit1), 32'd1);
        cyc();
        chk("hit1 second", 32'(rd_hit1), 32'd1);
        chk("reg5 first", rf_regs[5], 32'h1);
        cyc();
        chk("hit1 done", 32'(rd_hit1), 32'd0);
        chk("reg5 last", rf_regs[5], 32'h2);

        // Asynchronous reset while draining
        rf_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1;
            wb_addr  = 4'(10 + i);
            wb_data  = 32'hC0 + 32'(i);
            cyc();
        end
        wb_valid = 1'b0;
        rf_stall = 1'b0;
        cyc();
        chk("mid rf_ld", 32'(rf_ld), 32'd1);
        chk("mid count", 32'(count), 32'd2);
        wr0 = rf_writes;
        #1 rst_n = 1'b0;
        #1;
        chk("arst rf_ld", 32'(rf_ld), 32'd0);
        chk("arst count", 32'(count), 32'd0);
        chk("arst rd_hit1", 32'(rd_hit1), 32'd0);
        #1 rst_n = 1'b1;
        cyc();
        cyc();
        chk("arst writes", 32'(rf_writes - wr0), 32'd0);
        chk("arst wb_ready", 32'(wb_ready), 32'd1);
        chk("arst reg11", rf_regs[11], 32'd0);
        chk("arst reg12", rf_regs[12], 32'd0);
        chk_regs("final model", 0, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
